// File: rtl/cory_ser2_pkg.sv
// Shared definitions for the cory_ser2 width-halving serializer.
package cory_ser2_pkg;

  localparam int CORY_SER2_N = 16;

  typedef enum logic [1:0] {
    CORY_SER2_EMPTY = 2'd0,
    CORY_SER2_LO    = 2'd1,
    CORY_SER2_HI    = 2'd2
  } cory_ser2_state_e;

  // Only LO and HI present a beat; the unreachable 2'd3 counts as empty.
  function automatic logic cory_ser2_busy(cory_ser2_state_e s);
    return (s == CORY_SER2_LO) || (s == CORY_SER2_HI);
  endfunction

endpackage

// File: rtl/cory_ser2.sv
// Width-halving serializer: one Z=2N word in, low half then high half out.
// Optional o_z_last port under CORY_SER2_LAST_EN; simulation monitor under SIM with CORY_MON.
module cory_ser2
  import cory_ser2_pkg::*;
#(
  parameter int N = CORY_SER2_N,
  parameter int Z = 2 * N
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_a_v,
  input  logic [Z-1:0] i_a_d,
  output logic         o_a_r,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  input  logic         i_z_r
`ifdef CORY_SER2_LAST_EN
  ,
  output logic         o_z_last
`endif
);

  if (Z != 2 * N) begin : g_bad_width
    $error("cory_ser2: Z must equal 2*N");
  end

  cory_ser2_state_e state;
  logic [Z-1:0]     word;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CORY_SER2_EMPTY;
      word  <= '0;
    end else begin
      case (state)
        CORY_SER2_LO: begin
          if (i_z_r) state <= CORY_SER2_HI;
        end
        CORY_SER2_HI: begin
          if (i_z_r) begin
            if (i_a_v) begin
              word  <= i_a_d;
              state <= CORY_SER2_LO;
            end else begin
              state <= CORY_SER2_EMPTY;
            end
          end
        end
        default: begin
          if (i_a_v) begin
            word  <= i_a_d;
            state <= CORY_SER2_LO;
          end else begin
            state <= CORY_SER2_EMPTY;
          end
        end
      endcase
    end
  end

  // Ready leaks i_z_r only in HI, so a new word can follow the high beat without a bubble.
  assign o_a_r = !cory_ser2_busy(state) || ((state == CORY_SER2_HI) && i_z_r);
  assign o_z_v = cory_ser2_busy(state);

  always_comb begin
    o_z_d = word[N-1:0];
    if (state == CORY_SER2_HI) o_z_d = word[Z-1:N];
  end

`ifdef CORY_SER2_LAST_EN
  assign o_z_last = (state == CORY_SER2_HI);
`endif

`ifdef SIM
`ifdef CORY_MON
  cory_monitor #(.W(N)) u_mon (
    .clk    (clk),
    .reset_n(reset_n),
    .valid  (o_z_v),
    .ready  (i_z_r),
    .data   (o_z_d)
  );
`endif
`endif

endmodule

// File: doc/cory_ser2.md
# cory_ser2

Width-halving serializer for the consumer side of a two-operand packer. Accepts one Z = 2·N bit word per valid/ready handshake and emits it as two N-bit beats, low half (bits N-1:0) first, then high half (bits 2N-1:N). Registered, back-pressure-aware and bubble-free: sustains one input word every two cycles when the output is always ready.

## Interface
- N, 16, output beat width in bits
- Z, 2*N, input word width; any other value is illegal
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- i_a_v  input  1  input word valid
- i_a_d  input  Z  input word, {high half, low half}
- o_a_r  output  1  input ready
- o_z_v  output  1  output beat valid
- o_z_d  output  N  output beat data
- i_z_r  input  1  output beat ready
- o_z_last  output  1  high-half beat marker; present only with CORY_SER2_LAST_EN

## Operation
- Single clock clk; reset_n asynchronous, active-low, fixed.
- State machine, 2-bit state:
  - EMPTY: o_z_v=0, o_a_r=1; on i_a_v capture i_a_d into word register -> LO.
  - LO: o_z_v=1, o_z_d=word[N-1:0]; on i_z_r -> HI.
  - HI: o_z_v=1, o_z_d=word[Z-1:N]; o_a_r=i_z_r; on i_z_r and i_a_v capture new word -> LO; on i_z_r without i_a_v -> EMPTY.
- o_a_r = (state==EMPTY) | (state==HI & i_z_r); the only combinational input-to-output path.
- Word register loads only when i_a_v & o_a_r; it holds otherwise. Data is never modified, only selected.
- o_z_d holds stable while o_z_v=1 & i_z_r=0; o_z_v never drops without a handshake.
- i_a_v during LO is ignored (o_a_r=0); the upstream must hold.
- Reset at any time: state -> EMPTY, buffered word discarded, no partial beat delivered afterwards.
- Reset values: o_z_v=0, o_a_r=1, o_z_d=0 (word register cleared), o_z_last=0.

## Timing
- Latency: input handshake at edge k -> low beat valid in cycle k+1, high beat valid at earliest in k+2.
- Throughput: 1 word per 2 cycles with i_z_r held high and i_a_v held high; no idle cycle between words.
- Output stall: each beat holds for as many cycles as i_z_r=0.
- Simultaneous HI-beat handshake and input handshake in one cycle: the new word is loaded, its low beat is presented the next cycle.
- Input stall while in HI with i_z_r=1: goes EMPTY; o_z_v=0 next cycle.

## Configuration
- CORY_SER2_LAST_EN defined: port o_z_last exists, equals 1 exactly when state==HI (qualifies the high beat); reset value 0.
- Undefined: port absent; no other behaviour changes.
- Under SIM with CORY_MON, a cory_monitor of width N is attached to the o_z handshake.

## Structure
- Shared package: state encodings CORY_SER2_EMPTY=2'd0, CORY_SER2_LO=2'd1, CORY_SER2_HI=2'd2; value 2'd3 unreachable, decoded as EMPTY.
- No sub-module needed; FSM, word register and half-select mux live in one module. cory_monitor is the only instance, simulation only.

## Test plan
- Reset release, N=16, no input -> o_z_v=0, o_a_r=1, o_z_d=0 for 10 cycles.
- Single word 32'hBEEF_1234, i_z_r=1 -> beats 16'h1234 then 16'hBEEF on consecutive cycles, then o_z_v=0; with LAST_EN o_z_last=0,1.
- Back-to-back words 32'h0002_0001, 32'h0004_0003, 32'h0006_0005, i_a_v and i_z_r always high -> beats 1,2,3,4,5,6 on 6 consecutive cycles, o_a_r high every second cycle.
- Output stall: i_z_r=0 for 5 cycles during LO beat of 32'hAAAA_5555 -> o_z_d holds 16'h5555, o_a_r=0 throughout; release -> 16'hAAAA next.
- Random i_a_v/i_z_r at 50% over 1000 words -> scoreboard sees every low then high half in order, no loss or duplication.
- reset_n asserted mid-word after low beat 16'h1111 of 32'h2222_1111 -> o_z_v=0 immediately; after release 16'h2222 never appears.
